// File: rtl/retire_unit_n.sv
// N-wide in-order retire unit: ROB head selection, architectural map table, recovery/halt FSM.
// Optional RETIRE_PERF_EN adds mispredict and credit-stall performance counters.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef PR
`define PR 6
`endif
`ifndef ROB
`define ROB 5
`endif

package retire_unit_n_pkg;
  localparam int unsigned XLEN_W = `XLEN;
  localparam int unsigned PR_W   = `PR;
  localparam int unsigned ROB_W  = `ROB;

  typedef struct packed {
    logic              completed;
    logic [4:0]        arch_reg;
    logic [PR_W-1:0]   Tnew;
    logic              is_store;
    logic              halt;
    logic              precise_state_need;
    logic [XLEN_W-1:0] target_pc;
  } rob_entry_packet_t;
endpackage

module retire_unit_n
  import retire_unit_n_pkg::*;
#(
  parameter int unsigned RETIRE_WIDTH = 3,
  parameter int unsigned PR_BITS      = PR_W,
  parameter int unsigned ROB_BITS     = ROB_W,
  parameter int unsigned CNT_BITS     = 64
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  rob_entry_packet_t [RETIRE_WIDTH-1:0] rob_head_entry,
  input  logic [ROB_BITS-1:0]                  fl_distance,
  input  logic [$clog2(RETIRE_WIDTH+1)-1:0]    sq_retire_credit,
  output logic [RETIRE_WIDTH-1:0]              Retire_EN,
  output logic [RETIRE_WIDTH-1:0]              SQRetireEN,
  output logic [RETIRE_WIDTH-1:0]              retire_valid,
  output logic [$clog2(RETIRE_WIDTH+1)-1:0]    inst_count,
  output logic                                 BPRecoverEN,
  output logic [XLEN_W-1:0]                    target_pc,
  output logic [ROB_BITS-1:0]                  fl_recover_dis,
  output logic [31:0][PR_BITS-1:0]             recover_maptable,
  output logic                                 halt,
`ifdef RETIRE_PERF_EN
  output logic [31:0]                          perf_mispredicts,
  output logic [31:0]                          perf_stall_cycles,
`endif
  output logic [CNT_BITS-1:0]                  retired_total
);

  localparam int unsigned CW = $clog2(RETIRE_WIDTH + 1);
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RECOVER = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t                   state, state_n;
  logic                     run_c;
  logic                     blocked;
  logic [SW-1:0]            store_cnt;
  logic [CW-1:0]            wr_cnt;
  logic [CW-1:0]            ret_cnt;
  logic [RETIRE_WIDTH-1:0]  rv_c, ren_c, sq_c;
  logic                     halt_hit, mis_hit;
  logic [XLEN_W-1:0]        mis_pc;
  logic [ROB_BITS-1:0]      mis_dis;
  logic [31:0][PR_BITS-1:0] amt;

  // Combinational outputs are forced low while reset is held
  assign run_c = (state == RUN) && reset;

  // Oldest-to-youngest scan; the first slot that cannot retire blocks everything younger
  always_comb begin
    rv_c      = '0;
    ren_c     = '0;
    sq_c      = '0;
    store_cnt = '0;
    wr_cnt    = '0;
    ret_cnt   = '0;
    halt_hit  = 1'b0;
    mis_hit   = 1'b0;
    mis_pc    = '0;
    mis_dis   = '0;
    blocked   = !run_c;
    for (int k = int'(RETIRE_WIDTH) - 1; k >= 0; k--) begin
      if (!blocked) begin
        if (!rob_head_entry[k].completed ||
            (rob_head_entry[k].is_store &&
             ((store_cnt + SW'(1)) > SW'(sq_retire_credit)))) begin
          blocked = 1'b1;
        end else begin
          rv_c[k] = 1'b1;
          ret_cnt = ret_cnt + CW'(1);
          if (rob_head_entry[k].is_store) begin
            sq_c[k]   = 1'b1;
            store_cnt = store_cnt + SW'(1);
          end
          if (rob_head_entry[k].arch_reg != 5'd0) begin
            ren_c[k] = 1'b1;
            wr_cnt   = wr_cnt + CW'(1);
          end
          // Halt wins over a mispredict flagged in the same slot
          if (rob_head_entry[k].halt) begin
            halt_hit = 1'b1;
            blocked  = 1'b1;
          end else if (rob_head_entry[k].precise_state_need) begin
            mis_hit = 1'b1;
            mis_pc  = rob_head_entry[k].target_pc;
            mis_dis = fl_distance - ROB_BITS'(wr_cnt);
            blocked = 1'b1;
          end
        end
      end
    end
  end

  assign retire_valid     = rv_c;
  assign Retire_EN        = ren_c;
  assign SQRetireEN       = sq_c;
  assign inst_count       = ret_cnt;
  assign recover_maptable = amt;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; halt and mispredict cannot both fire since each blocks younger slots
  always_comb begin
    state_n = state;
    case (state)
      RUN: begin
        if (halt_hit) begin
          state_n = HALTED;
        end else if (mis_hit) begin
          state_n = RECOVER;
        end
      end
      RECOVER: state_n = RUN;
      HALTED:  state_n = HALTED;
      default: state_n = RUN;
    endcase
  end

  // AMT, recovery payload, halt flag and retire counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) begin
        amt[r] <= PR_BITS'(r);
      end
      BPRecoverEN    <= 1'b0;
      target_pc      <= '0;
      fl_recover_dis <= '0;
      halt           <= 1'b0;
      retired_total  <= '0;
    end else begin
      // Oldest first so the youngest writer of a duplicate arch_reg lands last
      for (int k = int'(RETIRE_WIDTH) - 1; k >= 0; k--) begin
        if (ren_c[k]) begin
          amt[rob_head_entry[k].arch_reg] <= PR_BITS'(rob_head_entry[k].Tnew);
        end
      end
      BPRecoverEN <= mis_hit;
      if (mis_hit) begin
        target_pc      <= mis_pc;
        fl_recover_dis <= mis_dis;
      end
      if (halt_hit) begin
        halt <= 1'b1;
      end
      retired_total <= retired_total + CNT_BITS'(ret_cnt);
    end
  end

`ifdef RETIRE_PERF_EN
  logic stall_c;

  // Oldest entry ready but nothing retired in RUN can only mean the store credit ran out
  assign stall_c = run_c && rob_head_entry[RETIRE_WIDTH-1].completed && (rv_c == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_mispredicts  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (mis_hit) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
      if (stall_c) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_retire_unit_n.sv
// Table-driven bench for retire_unit_n: combinational retire vectors plus a scoreboard
// of expected registered state (AMT, counter, recovery, halt) checked one cycle later.
module tb_retire_unit_n;
  import retire_unit_n_pkg::*;

  localparam int unsigned W  = 3;
  localparam int unsigned CW = 2;
  localparam int unsigned NV = 14;

  logic                        clock = 1'b0;
  logic                        reset = 1'b0;
  rob_entry_packet_t [W-1:0]   rob_head_entry;
  logic [ROB_W-1:0]            fl_distance;
  logic [CW-1:0]               sq_retire_credit;
  logic [W-1:0]                Retire_EN, SQRetireEN, retire_valid;
  logic [CW-1:0]               inst_count;
  logic                        BPRecoverEN;
  logic [XLEN_W-1:0]           target_pc;
  logic [ROB_W-1:0]            fl_recover_dis;
  logic [31:0][PR_W-1:0]       recover_maptable;
  logic                        halt;
  logic [63:0]                 retired_total;
`ifdef RETIRE_PERF_EN
  logic [31:0]                 perf_mispredicts, perf_stall_cycles;
`endif

  retire_unit_n dut (
    .clock            (clock),
    .reset            (reset),
    .rob_head_entry   (rob_head_entry),
    .fl_distance      (fl_distance),
    .sq_retire_credit (sq_retire_credit),
    .Retire_EN        (Retire_EN),
    .SQRetireEN       (SQRetireEN),
    .retire_valid     (retire_valid),
    .inst_count       (inst_count),
    .BPRecoverEN      (BPRecoverEN),
    .target_pc        (target_pc),
    .fl_recover_dis   (fl_recover_dis),
    .recover_maptable (recover_maptable),
    .halt             (halt),
`ifdef RETIRE_PERF_EN
    .perf_mispredicts (perf_mispredicts),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .retired_total    (retired_total)
  );

  always #5 clock = ~clock;

  typedef struct {
    rob_entry_packet_t [W-1:0] ent;
    logic [ROB_W-1:0]          fl;
    logic [CW-1:0]             credit;
    logic [W-1:0]              rv;
    logic [W-1:0]              ren;
    logic [W-1:0]              sq;
    logic [CW-1:0]             ic;
  } vec_t;

  typedef struct {
    logic [31:0][PR_W-1:0] amt;
    logic [63:0]           total;
    logic                  bp;
    logic [XLEN_W-1:0]     pc;
    logic [ROB_W-1:0]      dis;
    logic                  hlt;
  } exp_t;

  vec_t                  tbl [NV];
  exp_t                  sb [$];
  logic [31:0][PR_W-1:0] m_amt;
  logic [63:0]           m_total;
  logic                  m_halt;
  int                    checks = 0;
  int                    errors = 0;

  function automatic rob_entry_packet_t mk(input logic c, input int a, input int t,
                                           input logic st, input logic h, input logic p,
                                           input int pc);
    rob_entry_packet_t r;
    r.completed          = c;
    r.arch_reg           = 5'(a);
    r.Tnew               = PR_W'(t);
    r.is_store           = st;
    r.halt               = h;
    r.precise_state_need = p;
    r.target_pc          = XLEN_W'(pc);
    return r;
  endfunction

  function automatic logic [31:0][PR_W-1:0] ident();
    logic [31:0][PR_W-1:0] m;
    for (int r = 0; r < 32; r++) m[r] = PR_W'(r);
    return m;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Entries listed oldest (slot 2) first
  task automatic set_vec(input int i, input rob_entry_packet_t e2, input rob_entry_packet_t e1,
                         input rob_entry_packet_t e0, input int fl, input int credit,
                         input logic [W-1:0] rv, input logic [W-1:0] ren,
                         input logic [W-1:0] sq, input int ic);
    tbl[i].ent[2] = e2;
    tbl[i].ent[1] = e1;
    tbl[i].ent[0] = e0;
    tbl[i].fl     = ROB_W'(fl);
    tbl[i].credit = CW'(credit);
    tbl[i].rv     = rv;
    tbl[i].ren    = ren;
    tbl[i].sq     = sq;
    tbl[i].ic     = CW'(ic);
  endtask

  task automatic model_reset();
    m_amt   = ident();
    m_total = '0;
    m_halt  = 1'b0;
    sb.delete();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " retire_valid"}, 256'(retire_valid), 256'(0));
    chk({tag, " Retire_EN"}, 256'(Retire_EN), 256'(0));
    chk({tag, " SQRetireEN"}, 256'(SQRetireEN), 256'(0));
    chk({tag, " inst_count"}, 256'(inst_count), 256'(0));
    chk({tag, " maptable"}, 256'(recover_maptable), 256'(ident()));
    chk({tag, " BPRecoverEN"}, 256'(BPRecoverEN), 256'(0));
    chk({tag, " halt"}, 256'(halt), 256'(0));
    chk({tag, " retired_total"}, 256'(retired_total), 256'(0));
  endtask

  task automatic check_regs();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("maptable", 256'(recover_maptable), 256'(e.amt));
    chk("retired_total", 256'(retired_total), 256'(e.total));
    chk("BPRecoverEN", 256'(BPRecoverEN), 256'(e.bp));
    chk("halt", 256'(halt), 256'(e.hlt));
    if (e.bp) begin
      chk("target_pc", 256'(target_pc), 256'(e.pc));
      chk("fl_recover_dis", 256'(fl_recover_dis), 256'(e.dis));
    end
  endtask

  // Apply one vector for one clock: compare combinational outputs, queue registered expectations
  task automatic step(input int i);
    vec_t        v;
    exp_t        e;
    int unsigned wr;
    logic        mis;
    v = tbl[i];
    @(negedge clock);
    check_regs();
    rob_head_entry   = v.ent;
    fl_distance      = v.fl;
    sq_retire_credit = v.credit;
    #1;
    chk($sformatf("v%0d retire_valid", i), 256'(retire_valid), 256'(v.rv));
    chk($sformatf("v%0d Retire_EN", i), 256'(Retire_EN), 256'(v.ren));
    chk($sformatf("v%0d SQRetireEN", i), 256'(SQRetireEN), 256'(v.sq));
    chk($sformatf("v%0d inst_count", i), 256'(inst_count), 256'(v.ic));
    wr    = 0;
    mis   = 1'b0;
    e.pc  = '0;
    e.dis = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (v.rv[k]) begin
        if (v.ent[k].arch_reg != 5'd0) begin
          m_amt[v.ent[k].arch_reg] = v.ent[k].Tnew;
          wr++;
        end
        if (v.ent[k].halt) begin
          m_halt = 1'b1;
        end else if (v.ent[k].precise_state_need && !mis) begin
          mis   = 1'b1;
          e.pc  = v.ent[k].target_pc;
          e.dis = ROB_W'(32'(v.fl) - wr);
        end
      end
    end
    m_total = m_total + 64'(v.ic);
    e.amt   = m_amt;
    e.total = m_total;
    e.bp    = mis;
    e.hlt   = m_halt;
    sb.push_back(e);
  endtask

  initial begin
    //          completed arch Tnew store halt psn pc
    set_vec(0,  mk(1, 5, 40, 0, 0, 0, 0), mk(1, 6, 41, 0, 0, 0, 0), mk(1, 7, 42, 0, 0, 0, 0),
            0, 3, 3'b111, 3'b111, 3'b000, 3);
    set_vec(1,  mk(0, 1, 1, 0, 0, 0, 0), mk(1, 8, 43, 0, 0, 0, 0), mk(1, 9, 44, 0, 0, 0, 0),
            0, 3, 3'b000, 3'b000, 3'b000, 0);
    set_vec(2,  mk(1, 3, 10, 0, 0, 0, 0), mk(1, 0, 11, 0, 0, 1, 'h100), mk(1, 11, 12, 0, 0, 0, 0),
            9, 3, 3'b110, 3'b100, 3'b000, 2);
    set_vec(3,  mk(1, 16, 1, 0, 0, 0, 0), mk(1, 17, 2, 0, 0, 0, 0), mk(1, 18, 3, 0, 0, 0, 0),
            0, 3, 3'b000, 3'b000, 3'b000, 0);
    set_vec(4,  mk(1, 0, 0, 1, 0, 0, 0), mk(1, 0, 0, 1, 0, 0, 0), mk(1, 12, 45, 0, 0, 0, 0),
            0, 1, 3'b100, 3'b000, 3'b100, 1);
    set_vec(5,  mk(1, 0, 0, 1, 0, 0, 0), mk(1, 12, 50, 0, 0, 0, 0), mk(0, 19, 5, 0, 0, 0, 0),
            0, 2, 3'b110, 3'b010, 3'b100, 2);
    set_vec(6,  mk(1, 13, 51, 0, 0, 0, 0), mk(1, 0, 0, 1, 0, 0, 0), mk(1, 20, 6, 0, 0, 0, 0),
            0, 0, 3'b100, 3'b100, 3'b000, 1);
    set_vec(7,  mk(1, 4, 20, 0, 0, 0, 0), mk(1, 4, 21, 0, 0, 0, 0), mk(1, 0, 30, 0, 0, 0, 0),
            0, 3, 3'b111, 3'b110, 3'b000, 3);
    set_vec(8,  mk(1, 0, 0, 1, 0, 0, 0), mk(1, 21, 7, 0, 0, 0, 0), mk(1, 22, 8, 0, 0, 0, 0),
            0, 0, 3'b000, 3'b000, 3'b000, 0);
    set_vec(9,  mk(1, 15, 61, 0, 0, 1, 'h200), mk(1, 23, 9, 0, 0, 0, 0), mk(1, 24, 10, 0, 0, 0, 0),
            0, 3, 3'b100, 3'b100, 3'b000, 1);
    set_vec(10, mk(1, 16, 1, 0, 0, 0, 0), mk(1, 17, 2, 0, 0, 0, 0), mk(1, 18, 3, 0, 0, 0, 0),
            0, 3, 3'b000, 3'b000, 3'b000, 0);
    set_vec(11, mk(1, 14, 60, 0, 1, 1, 'h300), mk(1, 25, 11, 0, 0, 0, 0), mk(1, 26, 12, 0, 0, 0, 0),
            5, 3, 3'b100, 3'b100, 3'b000, 1);
    set_vec(12, mk(1, 27, 13, 0, 0, 0, 0), mk(1, 28, 14, 0, 0, 0, 0), mk(1, 29, 15, 0, 0, 0, 0),
            0, 3, 3'b000, 3'b000, 3'b000, 0);
    set_vec(13, mk(1, 27, 13, 0, 0, 0, 0), mk(1, 28, 14, 0, 0, 0, 0), mk(1, 29, 15, 0, 0, 0, 0),
            0, 3, 3'b000, 3'b000, 3'b000, 0);
    model_reset();

    // Completed entries present while reset is held must not retire
    rob_head_entry   = tbl[0].ent;
    fl_distance      = '0;
    sq_retire_credit = CW'(3);
    repeat (2) @(negedge clock);
    #1;
    reset_checks("por");
    rob_head_entry = '0;
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) step(i);
    @(negedge clock);
    check_regs();

    // Reset while HALTED
    rob_head_entry = tbl[12].ent;
    reset = 1'b0;
    #1;
    reset_checks("halted_rst");
    model_reset();
    rob_head_entry = '0;
    @(negedge clock);
    reset = 1'b1;
    step(0);

    // Reset while RECOVER
    step(2);
    @(negedge clock);
    check_regs();
    rob_head_entry = tbl[3].ent;
    reset = 1'b0;
    #1;
    reset_checks("recover_rst");
    model_reset();
    rob_head_entry = '0;
    @(negedge clock);
    reset = 1'b1;
    step(0);
    @(negedge clock);
    check_regs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_unit_n.md
Name: retire_unit_n

Overview:
- Parametrised N-wide in-order retire unit. Successor to the fixed 3-wide combinational retire stage.
- Sits between the ROB head and the AMT, free list, store queue and fetch.
- Holds the architectural map table internally and registers the branch-recovery event into a one-cycle recovery state.
- Adds store-queue retire credits, a sticky halt state and a retired-instruction counter.

Parameters:
RETIRE_WIDTH, 3, number of ROB head slots examined per cycle; slot RETIRE_WIDTH-1 is oldest.
PR_BITS, `PR, physical register tag width.
ROB_BITS, `ROB, width of the free-list distance.
CNT_BITS, 64, width of the retired-instruction counter.

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-low reset (asserted when 0).
rob_head_entry  in  ROB_ENTRY_PACKET[RETIRE_WIDTH-1:0]  head slots; fields used: completed, arch_reg, Tnew, is_store, halt, precise_state_need, target_pc.
fl_distance  in  ROB_BITS  current free-list distance for reg-writing in-flight instructions.
sq_retire_credit  in  $clog2(RETIRE_WIDTH+1)  max stores the SQ accepts this cycle.
Retire_EN  out  RETIRE_WIDTH  slot retires and writes arch_reg≠0 (free-list release); combinational.
SQRetireEN  out  RETIRE_WIDTH  slot retires and is a store; combinational.
retire_valid  out  RETIRE_WIDTH  slot retires (ROB head advance); combinational.
inst_count  out  $clog2(RETIRE_WIDTH+1)  popcount of retire_valid.
BPRecoverEN  out  1  registered one-cycle recovery pulse.
target_pc  out  `XLEN  registered recovery PC; valid while BPRecoverEN.
fl_recover_dis  out  ROB_BITS  registered free-list rollback distance; valid while BPRecoverEN.
recover_maptable  out  [31:0][PR_BITS-1:0]  registered AMT contents (always current).
halt  out  1  sticky halt.
retired_total  out  CNT_BITS  total instructions retired since reset.

Behaviour:
- States: RUN, RECOVER, HALTED. Reset → RUN.
- Reset values:
  - all registered outputs 0, except AMT[r] = r for r = 0..31;
  - combinational outputs 0 while in reset.
- Slot selection in RUN, scanning from oldest to youngest. Slot i retires iff:
  - completed = 1, and every older slot retired;
  - no older retiring slot had halt or precise_state_need;
  - stores among retiring slots, including i, ≤ sq_retire_credit.
  - The first slot failing any rule blocks all younger slots.
- In RECOVER and HALTED, retire_valid, Retire_EN, SQRetireEN and inst_count are all 0.
- AMT update:
  - at the clock edge, each retiring slot with arch_reg ≠ 0 writes AMT[arch_reg] <= Tnew;
  - slots are applied oldest first, so a younger slot wins on a duplicate arch_reg;
  - AMT[0] is never written.
- Misprediction: if a retiring slot k has precise_state_need = 1 and halt = 0, then at the next edge:
  - state <= RECOVER;
  - target_pc <= slot k target_pc;
  - fl_recover_dis <= fl_distance − (count of retiring slots, up to and including k, with arch_reg ≠ 0), modulo 2^ROB_BITS;
  - BPRecoverEN = 1 for exactly that one cycle, and recover_maptable then already reflects slot k's update.
- RECOVER → RUN unconditionally after one cycle; BPRecoverEN returns to 0.
- Halt: a retiring slot with halt = 1 causes state <= HALTED and halt <= 1. Halt takes priority over precise_state_need in the same slot. HALTED is left only by reset.
- retired_total += inst_count each edge, wrapping modulo 2^CNT_BITS.
- sq_retire_credit = 0: the oldest store blocks retirement; older non-stores still retire.
- Reset asserted mid-RECOVER or mid-HALTED returns the block to RUN, with the AMT set to identity and BPRecoverEN cleared.

Optional Feature:
RETIRE_PERF_EN
- Defined: adds outputs perf_mispredicts (32-bit, +1 on each RUN→RECOVER transition) and perf_stall_cycles (32-bit, +1 on each RUN cycle where the oldest slot is completed but retire_valid = 0 because of credit). Both reset to 0 and wrap.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- After reset, RETIRE_WIDTH=3, all three slots completed, arch_reg 5/6/7, Tnew 40/41/42 → retire_valid=111, Retire_EN=111, inst_count=3; next cycle AMT[5,6,7]=40,41,42 and retired_total=3.
- Oldest slot not completed, younger ones completed → retire_valid=000, AMT unchanged.
- Middle slot mispredict with target_pc 0x100 and fl_distance=9, older slot arch_reg=3, middle slot arch_reg=0 → retire_valid=110; next cycle BPRecoverEN=1, target_pc=0x100, fl_recover_dis=8; the cycle after, BPRecoverEN=0 and state is RUN.
- Two stores with sq_retire_credit=1 → only the oldest store retires (SQRetireEN=100); next cycle with credit=2, the remaining store retires.
- Halt in the oldest slot with younger slots completed → retire_valid=100; halt=1 from the next cycle and stays 1; retire_valid stays 0 despite completed entries until reset deasserts.
- Duplicate arch_reg 4 in slots 2 and 1 with Tnew 20/21 → AMT[4]=21; arch_reg 0 with Tnew 30 → AMT[0] stays 0 and Retire_EN for that slot is 0.
